// File: rtl/dsp_pkg.sv
// Shared widths, state encoding and the signed tap-product helper
// for the 8-tap time-multiplexed FIR MAC engine.
package dsp_pkg;
    localparam int DATA_W = 9;
    localparam int COEF_W = 9;
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int NTAPS  = 8;
    localparam int IDX_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } mac_state_t;

    // Full-precision signed product, sign-extended to accumulator width.
    function automatic logic signed [ACC_W-1:0] mac_product(
        input logic signed [DATA_W-1:0] x,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(x) * PROD_W'(c);
        return ACC_W'(p);
    endfunction
endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank,
// commit copies the shadow (with any same-cycle write) into the active bank.
module fir_coef_bank
    import dsp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IDX_W-1:0]         waddr,
    input  logic signed [COEF_W-1:0] wdata,
    input  logic                     commit,
    input  logic [IDX_W-1:0]         ridx,
    output logic signed [COEF_W-1:0] rdata
);
    logic signed [COEF_W-1:0] shadow [NTAPS];
    logic signed [COEF_W-1:0] active [NTAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (we)
                shadow[waddr] <= wdata;
            // Forward a write that coincides with the commit so it is not lost.
            if (commit) begin
                for (int i = 0; i < NTAPS; i++)
                    active[i] <= (we && (waddr == IDX_W'(i))) ? wdata : shadow[i];
            end
        end
    end

    assign rdata = active[ridx];
endmodule

// File: rtl/fir_mac_engine.sv
// 8-tap FIR: captures a parallel snapshot on frame_strobe and computes
// sum(x[i]*c[i]) over 8 MAC cycles, one result per 8 enabled cycles.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for a frame strobe
//  ST_MAC  | accumulating tap idx; at idx 7 emit y, reload if strobed
module fir_mac_engine
    import dsp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     frame_strobe,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    input  logic signed [DATA_W-1:0] x4,
    input  logic signed [DATA_W-1:0] x5,
    input  logic signed [DATA_W-1:0] x6,
    input  logic signed [DATA_W-1:0] x7,
    input  logic                     coef_we,
    input  logic [IDX_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     overrun_clr,
    output logic signed [ACC_W-1:0]  y,
    output logic                     y_valid,
    output logic                     busy,
    output logic                     overrun
);
    mac_state_t               state, state_nxt;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [DATA_W-1:0] snap [NTAPS];
    logic signed [DATA_W-1:0] x_in [NTAPS];
    logic signed [COEF_W-1:0] coef_rd;
    logic                     last_tap;
    logic                     accept;
    logic                     reject;

    always_comb begin
        x_in[0] = x0;
        x_in[1] = x1;
        x_in[2] = x2;
        x_in[3] = x3;
        x_in[4] = x4;
        x_in[5] = x5;
        x_in[6] = x6;
        x_in[7] = x7;
    end

    fir_coef_bank u_coef_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (coef_we),
        .waddr  (coef_addr),
        .wdata  (coef_wdata),
        .commit (accept),
        .ridx   (idx),
        .rdata  (coef_rd)
    );

    always_comb begin
        last_tap  = (idx == IDX_W'(NTAPS - 1));
        accept    = en && frame_strobe &&
                    ((state == ST_IDLE) || ((state == ST_MAC) && last_tap));
        reject    = en && frame_strobe && (state == ST_MAC) && !last_tap;
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_MAC;
            ST_MAC:  if (en && last_tap && !accept) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        prod    = mac_product(snap[idx], coef_rd);
        acc_sum = acc + prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < NTAPS; i++)
                snap[i] <= '0;
        end else begin
            y_valid <= 1'b0;
            busy    <= (state_nxt == ST_MAC);

            // A rejected strobe outranks a clear in the same cycle.
            if (reject)
                overrun <= 1'b1;
            else if (en && overrun_clr)
                overrun <= 1'b0;

            if (en && (state == ST_MAC)) begin
                acc <= acc_sum;
                idx <= idx + IDX_W'(1);
                if (last_tap) begin
                    y       <= acc_sum;
                    y_valid <= 1'b1;
                end
            end

            // Placed after the MAC update so a back-to-back reload wins.
            if (accept) begin
                idx <= '0;
                acc <= '0;
                for (int i = 0; i < NTAPS; i++)
                    snap[i] <= x_in[i];
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: directed vector table, random frames
// against a sum-of-products model, and multi-cycle corner sequences.
module tb_fir_mac_engine;
    import dsp_pkg::*;

    logic clk = 1'b0;
    logic rst, en, frame_strobe, coef_we, overrun_clr;
    logic [DATA_W-1:0] x_drv [NTAPS];
    logic [IDX_W-1:0]  coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic [ACC_W-1:0]  y;
    logic y_valid, busy, overrun;

    int checks = 0;
    int errors = 0;
    int shadow_m [NTAPS];

    typedef struct {
        string name;
        int    xs [NTAPS];
        int    cs [NTAPS];
        int    exp_y;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    fir_mac_engine dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .frame_strobe (frame_strobe),
        .x0           (x_drv[0]),
        .x1           (x_drv[1]),
        .x2           (x_drv[2]),
        .x3           (x_drv[3]),
        .x4           (x_drv[4]),
        .x5           (x_drv[5]),
        .x6           (x_drv[6]),
        .x7           (x_drv[7]),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_wdata   (coef_wdata),
        .overrun_clr  (overrun_clr),
        .y            (y),
        .y_valid      (y_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_y(input int xs [NTAPS], input int cs [NTAPS]);
        int s = 0;
        for (int i = 0; i < NTAPS; i++)
            s += xs[i] * cs[i];
        return s;
    endfunction

    function automatic int rnd9();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    task automatic set_x(input int xs [NTAPS]);
        for (int i = 0; i < NTAPS; i++)
            x_drv[i] = DATA_W'(xs[i]);
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we    = 1'b1;
        coef_addr  = IDX_W'(addr);
        coef_wdata = COEF_W'(val);
        step();
        coef_we    = 1'b0;
        shadow_m[addr] = val;
    endtask

    task automatic load_coefs(input int cs [NTAPS]);
        for (int i = 0; i < NTAPS; i++)
            write_coef(i, cs[i]);
    endtask

    task automatic run_frame(input string name, input int xs [NTAPS], input int exp_y);
        int lat = 0;
        int busy_cnt = 0;
        set_x(xs);
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
        if (busy) busy_cnt++;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            if (busy) busy_cnt++;
            if (y_valid) lat = k;
        end
        chk({name, " latency"}, lat, 8);
        chk({name, " y"}, $signed(y), exp_y);
        chk({name, " busy cycles"}, busy_cnt, 8);
        step();
        chk({name, " y_valid single"}, y_valid, 0);
    endtask

    task automatic wait_result(input string name, input int exp_lat, input int exp_y);
        int lat = 0;
        for (int k = 1; k <= 24 && lat == 0; k++) begin
            step();
            if (y_valid) lat = k;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " y"}, $signed(y), exp_y);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs [NTAPS];
        int cs [NTAPS];
        int fr [4][NTAPS];
        int expv [4];
        int e, pulses, busy_low, lat;

        rst = 1'b1; en = 1'b1; frame_strobe = 1'b0; coef_we = 1'b0;
        overrun_clr = 1'b0; coef_addr = '0; coef_wdata = '0;
        for (int i = 0; i < NTAPS; i++) begin
            x_drv[i] = '0;
            shadow_m[i] = 0;
        end
        repeat (3) step();
        rst = 1'b0;
        chk("reset y", y, 0);
        chk("reset y_valid", y_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset overrun", overrun, 0);

        // Directed vectors with hand-derived results.
        vecs[0].name = "ones";
        vecs[1].name = "neg coef";
        vecs[2].name = "most negative";
        vecs[3].name = "mixed";
        vecs[4].name = "max positive";
        for (int i = 0; i < NTAPS; i++) begin
            vecs[0].xs[i] = i + 1;          vecs[0].cs[i] = 1;
            vecs[1].xs[i] = (i == 0) ? 255 : 100;
            vecs[1].cs[i] = (i == 0) ? -1 : 0;
            vecs[2].xs[i] = -256;           vecs[2].cs[i] = -256;
            vecs[3].xs[i] = (i % 2 == 0) ? (i + 1) : -(i + 1);
            vecs[3].cs[i] = 2;
            vecs[4].xs[i] = 255;            vecs[4].cs[i] = 255;
        end
        vecs[0].exp_y = 36;
        vecs[1].exp_y = -255;
        vecs[2].exp_y = 524288;
        vecs[3].exp_y = -8;
        vecs[4].exp_y = 520200;
        for (int v = 0; v < 5; v++) begin
            load_coefs(vecs[v].cs);
            run_frame(vecs[v].name, vecs[v].xs, vecs[v].exp_y);
        end

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NTAPS; i++) begin
                xs[i] = rnd9();
                cs[i] = rnd9();
            end
            load_coefs(cs);
            run_frame("random", xs, model_y(xs, shadow_m));
        end

        // Back-to-back frames: strobe at every 8th edge.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NTAPS; i++) begin
                fr[f][i] = rnd9();
                xs[i] = fr[f][i];
            end
            expv[f] = model_y(xs, shadow_m);
        end
        pulses = 0;
        busy_low = 0;
        for (int c = 0; c <= 36; c++) begin
            frame_strobe = (c % 8 == 0) && (c < 32);
            if (frame_strobe) begin
                for (int i = 0; i < NTAPS; i++) xs[i] = fr[c / 8][i];
                set_x(xs);
            end
            step();
            if (y_valid) begin
                pulses++;
                chk("b2b pulse time", c, 8 * pulses);
                if (pulses <= 4) chk("b2b y", $signed(y), expv[pulses - 1]);
            end
            if (c < 32 && !busy) busy_low++;
        end
        frame_strobe = 1'b0;
        chk("b2b pulses", pulses, 4);
        chk("b2b busy gaps", busy_low, 0);
        chk("b2b overrun", overrun, 0);

        // Coefficient write mid-frame goes to shadow only; same-cycle write at strobe commits.
        for (int i = 0; i < NTAPS; i++) xs[i] = rnd9();
        e = model_y(xs, shadow_m);
        set_x(xs);
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
        coef_we = 1'b1; coef_addr = 3'd3; coef_wdata = COEF_W'(-77);
        step();
        coef_addr = 3'd5; coef_wdata = COEF_W'(91);
        step();
        coef_we = 1'b0;
        shadow_m[3] = -77;
        shadow_m[5] = 91;
        wait_result("coef mid-frame old set", 6, e);
        for (int i = 0; i < NTAPS; i++) xs[i] = rnd9();
        set_x(xs);
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = COEF_W'(-200);
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
        coef_we = 1'b0;
        shadow_m[0] = -200;
        wait_result("coef new set", 8, model_y(xs, shadow_m));

        // Enable low for 4 cycles mid-frame delays the result by 4.
        for (int i = 0; i < NTAPS; i++) xs[i] = rnd9();
        e = model_y(xs, shadow_m);
        set_x(xs);
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
        lat = 0;
        for (int c = 1; c <= 24 && lat == 0; c++) begin
            en = (c < 3) || (c > 6);
            step();
            if (y_valid) lat = c;
        end
        en = 1'b1;
        chk("en stall latency", lat, 12);
        chk("en stall y", $signed(y), e);

        // Strobe 3 cycles into MAC is rejected; result unaffected.
        for (int i = 0; i < NTAPS; i++) xs[i] = rnd9();
        e = model_y(xs, shadow_m);
        set_x(xs);
        lat = 0;
        for (int c = 0; c <= 16 && lat == 0; c++) begin
            frame_strobe = (c == 0) || (c == 3);
            if (c == 3) begin
                for (int i = 0; i < NTAPS; i++) xs[i] = rnd9();
                set_x(xs);
            end
            step();
            if (c == 2) chk("overrun before", overrun, 0);
            if (c == 3) chk("overrun set", overrun, 1);
            if (y_valid) lat = c;
        end
        frame_strobe = 1'b0;
        chk("overrun frame latency", lat, 8);
        chk("overrun frame y", $signed(y), e);
        step();
        chk("overrun sticky", overrun, 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("overrun cleared", overrun, 0);

        // Set wins over clear in the same cycle; left set so reset must clear it.
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
        step();
        frame_strobe = 1'b1;
        overrun_clr = 1'b1;
        step();
        frame_strobe = 1'b0;
        overrun_clr = 1'b0;
        chk("overrun set wins", overrun, 1);
        repeat (8) step();

        // Reset mid-MAC aborts the frame and clears both coefficient banks.
        for (int i = 0; i < NTAPS; i++) xs[i] = rnd9() | 1;
        set_x(xs);
        frame_strobe = 1'b1;
        step();
        frame_strobe = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst mid y", y, 0);
        chk("rst mid busy", busy, 0);
        chk("rst mid overrun", overrun, 0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (y_valid) pulses++;
        end
        chk("rst mid no y_valid", pulses, 0);
        for (int i = 0; i < NTAPS; i++) shadow_m[i] = 0;
        run_frame("post-reset zero coefs", xs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
